// File: rtl/rgb_seq_pkg.sv
// Shared definitions for the RGB colour sequencer: controller state
// encoding, the colour codes understood by the downstream RGB converter,
// and the default table geometry.
package rgb_seq_pkg;

  localparam int unsigned DWELL_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } seq_state_e;

  // Converter colour encoding, bit order {R,G,B}.
  localparam logic [2:0] COL_BLACK   = 3'd0;
  localparam logic [2:0] COL_BLUE    = 3'd1;
  localparam logic [2:0] COL_GREEN   = 3'd2;
  localparam logic [2:0] COL_CYAN    = 3'd3;
  localparam logic [2:0] COL_RED     = 3'd4;
  localparam logic [2:0] COL_MAGENTA = 3'd5;
  localparam logic [2:0] COL_YELLOW  = 3'd6;
  localparam logic [2:0] COL_WHITE   = 3'd7;

endpackage

// File: rtl/rgb_colour_sequencer_if.sv
// Table configuration port of the colour sequencer (valid/ready write).
//   cfg_valid  : write request from the host
//   cfg_ready  : sequencer can accept a write (idle only)
//   cfg_addr   : table entry to write
//   cfg_colour : colour code of the entry
//   cfg_dwell  : entry is displayed for cfg_dwell+1 cycles
//   cfg_last   : entry ends the sequence
interface rgb_colour_sequencer_if #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DWELL_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [2:0]         cfg_colour;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_last;

  modport master (
    output cfg_valid, cfg_addr, cfg_colour, cfg_dwell, cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_colour, cfg_dwell, cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/rgb_seq_table.sv
// Sequence table: DEPTH entries of {colour, dwell, last}.
// Synchronous write and clear, asynchronous reads.
//   clk, rst          : clock, synchronous active-high clear of all entries
//   we, waddr, w*     : write port
//   ra_addr / ra_last : read port for the "last" flag of the current entry
//   rb_addr / rb_*    : read port for colour/dwell of the entry being loaded
module rgb_seq_table #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [2:0]         wcolour,
  input  logic [DWELL_W-1:0] wdwell,
  input  logic               wlast,
  input  logic [ADDR_W-1:0]  ra_addr,
  output logic               ra_last,
  input  logic [ADDR_W-1:0]  rb_addr,
  output logic [2:0]         rb_colour,
  output logic [DWELL_W-1:0] rb_dwell
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [2:0]         colour_q [DEPTH];
  logic [2:0]         colour_d [DEPTH];
  logic [DWELL_W-1:0] dwell_q  [DEPTH];
  logic [DWELL_W-1:0] dwell_d  [DEPTH];
  logic               last_q   [DEPTH];
  logic               last_d   [DEPTH];

  always_comb begin
    colour_d = colour_q;
    dwell_d  = dwell_q;
    last_d   = last_q;
    if (we) begin
      colour_d[waddr] = wcolour;
      dwell_d[waddr]  = wdwell;
      last_d[waddr]   = wlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        colour_q[i] <= '0;
        dwell_q[i]  <= '0;
        last_q[i]   <= 1'b0;
      end
    end else begin
      colour_q <= colour_d;
      dwell_q  <= dwell_d;
      last_q   <= last_d;
    end
  end

  assign ra_last   = last_q[ra_addr];
  assign rb_colour = colour_q[rb_addr];
  assign rb_dwell  = dwell_q[rb_addr];

endmodule

// File: rtl/rgb_colour_sequencer.sv
// Programmable colour-sequence controller feeding an RGB converter.
// Steps through a table of {colour, dwell, last} entries with hold,
// manual step and stop controls. All outputs are registered.
//   clk, rst          : clock, synchronous active-high reset
//   cfg               : table write port (accepted only while idle)
//   start/hold/step/stop : sequence controls
//   colour, enable    : converter drive
//   busy              : running or paused
//   step_idx          : current table index
//   wrap              : one-cycle pulse when the sequence returns to entry 0
module rgb_colour_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  rgb_colour_sequencer_if.slave cfg,
  input  logic              start,
  input  logic              hold,
  input  logic              step,
  input  logic              stop,
  output logic [2:0]        colour,
  output logic              enable,
  output logic              busy,
  output logic [ADDR_W-1:0] step_idx,
  output logic              wrap
);
  seq_state_e         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0]         colour_q, colour_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  step_idx_q, step_idx_d;
  logic               wrap_q, wrap_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic               cur_last;
  logic               adv_wrap;
  logic [ADDR_W-1:0]  adv_idx;
  logic [ADDR_W-1:0]  rd_addr;
  logic [2:0]         rd_colour;
  logic [DWELL_W-1:0] rd_dwell;
  logic               advance;

  // Next index is needed before the table can supply the entry to load,
  // so the table has a separate port for the current entry's last flag.
  assign adv_wrap = cur_last || (&step_idx_q);
  assign adv_idx  = adv_wrap ? '0 : step_idx_q + ADDR_W'(1);
  assign rd_addr  = (state_q == IDLE) ? '0 : adv_idx;

  rgb_seq_table #(
    .ADDR_W  (ADDR_W),
    .DWELL_W (DWELL_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .we        (cfg.cfg_valid && cfg_ready_q),
    .waddr     (cfg.cfg_addr),
    .wcolour   (cfg.cfg_colour),
    .wdwell    (cfg.cfg_dwell),
    .wlast     (cfg.cfg_last),
    .ra_addr   (step_idx_q),
    .ra_last   (cur_last),
    .rb_addr   (rd_addr),
    .rb_colour (rd_colour),
    .rb_dwell  (rd_dwell)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    colour_d    = colour_q;
    enable_d    = enable_q;
    busy_d      = busy_q;
    step_idx_d  = step_idx_q;
    wrap_d      = 1'b0;
    cfg_ready_d = cfg_ready_q;
    advance     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = RUN;
          step_idx_d  = '0;
          colour_d    = rd_colour;
          cnt_d       = rd_dwell;
          enable_d    = 1'b1;
          busy_d      = 1'b1;
          cfg_ready_d = 1'b0;
        end
      end
      RUN: begin
        if (stop)                state_d = IDLE;
        else if (hold)           state_d = PAUSE;
        else if (cnt_q != '0)    cnt_d   = cnt_q - DWELL_W'(1);
        else                     advance = 1'b1;
      end
      PAUSE: begin
        if (stop)                state_d = IDLE;
        else if (!hold)          state_d = RUN;
        else if (step)           advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      step_idx_d = adv_idx;
      colour_d   = rd_colour;
      cnt_d      = rd_dwell;
      wrap_d     = adv_wrap;
    end

    if (state_q != IDLE && state_d == IDLE) begin
      colour_d    = COL_BLACK;
      enable_d    = 1'b0;
      busy_d      = 1'b0;
      step_idx_d  = '0;
      cfg_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      colour_q    <= COL_BLACK;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      step_idx_q  <= '0;
      wrap_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      colour_q    <= colour_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      step_idx_q  <= step_idx_d;
      wrap_q      <= wrap_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign colour        = colour_q;
  assign enable        = enable_q;
  assign busy          = busy_q;
  assign step_idx      = step_idx_q;
  assign wrap          = wrap_q;
  assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_rgb_colour_sequencer.sv
// Directed, table-driven bench for rgb_colour_sequencer.
module tb_rgb_colour_sequencer;
  import rgb_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, hold, step, stop;
  logic [2:0] colour;
  logic       enable, busy, wrap;
  logic [2:0] step_idx;

  always #5 clk = ~clk;

  rgb_colour_sequencer_if #(.ADDR_W(3), .DWELL_W(8)) cfg_if ();

  rgb_colour_sequencer #(.DWELL_W(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg_if),
    .start    (start),
    .hold     (hold),
    .step     (step),
    .stop     (stop),
    .colour   (colour),
    .enable   (enable),
    .busy     (busy),
    .step_idx (step_idx),
    .wrap     (wrap)
  );

  typedef struct {
    logic       start, hold, step, stop;
    logic [2:0] colour;
    logic       enable, busy;
    logic [2:0] idx;
    logic       wrap, rdy;
  } vec_t;

  vec_t vq[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [2:0] c, logic e, logic b,
                       logic [2:0] i, logic w, logic r);
    n_vec++;
    if ({colour, enable, busy, step_idx, wrap, cfg_if.cfg_ready} !== {c, e, b, i, w, r}) begin
      n_bad++;
      $display("FAIL %s: got colour=%0d en=%b busy=%b idx=%0d wrap=%b rdy=%b, want colour=%0d en=%b busy=%b idx=%0d wrap=%b rdy=%b",
               name, colour, enable, busy, step_idx, wrap, cfg_if.cfg_ready, c, e, b, i, w, r);
    end
  endtask

  // Vector expecting an active (RUN/PAUSE) sequencer.
  function automatic void add(logic st, logic ho, logic sp, logic so,
                              logic [2:0] c, logic [2:0] i, logic w);
    vec_t v;
    v.start = st; v.hold = ho; v.step = sp; v.stop = so;
    v.colour = c; v.enable = 1'b1; v.busy = 1'b1; v.idx = i; v.wrap = w; v.rdy = 1'b0;
    vq.push_back(v);
  endfunction

  // Vector expecting the idle output state.
  function automatic void add_idle(logic st, logic ho, logic sp, logic so);
    vec_t v;
    v.start = st; v.hold = ho; v.step = sp; v.stop = so;
    v.colour = 3'd0; v.enable = 1'b0; v.busy = 1'b0; v.idx = 3'd0; v.wrap = 1'b0; v.rdy = 1'b1;
    vq.push_back(v);
  endfunction

  task automatic run(string name);
    for (int k = 0; k < vq.size(); k++) begin
      start = vq[k].start; hold = vq[k].hold; step = vq[k].step; stop = vq[k].stop;
      tick();
      check($sformatf("%s[%0d]", name, k), vq[k].colour, vq[k].enable, vq[k].busy,
            vq[k].idx, vq[k].wrap, vq[k].rdy);
    end
    start = 1'b0; hold = 1'b0; step = 1'b0; stop = 1'b0;
    vq.delete();
  endtask

  task automatic cfg_write(logic [2:0] a, logic [2:0] c, logic [7:0] d, logic l);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_colour = c;
    cfg_if.cfg_dwell = d; cfg_if.cfg_last = l;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; hold = 1'b0; step = 1'b0; stop = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_colour = '0;
    cfg_if.cfg_dwell = '0; cfg_if.cfg_last = 1'b0;

    // Reset with start held: start must be ignored.
    tick(); check("reset0", 3'd0, 0, 0, 3'd0, 0, 1);
    tick(); check("reset1", 3'd0, 0, 0, 3'd0, 0, 1);
    rst = 1'b0; start = 1'b0;
    tick(); check("post_reset", 3'd0, 0, 0, 3'd0, 0, 1);

    // Three-entry sequence: colours 1 (3 cycles), 4 (1), 7 (2), loop.
    cfg_write(3'd0, COL_BLUE,  8'd2, 1'b0);
    cfg_write(3'd1, COL_RED,   8'd0, 1'b0);
    cfg_write(3'd2, COL_WHITE, 8'd1, 1'b1);

    add(1,0,0,0, 3'd1, 3'd0, 0);
    add(0,0,0,0, 3'd1, 3'd0, 0);
    add(0,0,1,0, 3'd1, 3'd0, 0);   // step in RUN ignored
    add(0,0,0,0, 3'd4, 3'd1, 0);
    add(0,0,0,0, 3'd7, 3'd2, 0);
    add(0,0,0,0, 3'd7, 3'd2, 0);
    add(1,0,0,0, 3'd1, 3'd0, 1);   // wrap; start outside IDLE ignored
    add(0,0,0,0, 3'd1, 3'd0, 0);
    add(0,0,0,0, 3'd1, 3'd0, 0);
    add(0,0,0,0, 3'd4, 3'd1, 0);
    add(0,0,0,0, 3'd7, 3'd2, 0);
    add(0,0,0,0, 3'd7, 3'd2, 0);   // one cycle of entry 2 counted
    for (int k = 0; k < 5; k++) add(0,1,0,0, 3'd7, 3'd2, 0);
    add(0,0,0,0, 3'd7, 3'd2, 0);   // resume: one remaining cycle
    add(0,0,0,0, 3'd1, 3'd0, 1);
    add(0,1,0,0, 3'd1, 3'd0, 0);   // pause on entry 0
    add(0,1,1,0, 3'd4, 3'd1, 0);   // manual step
    run("seq3");

    // Config write while paused must be refused.
    hold = 1'b1;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 3'd1; cfg_if.cfg_colour = COL_MAGENTA;
    cfg_if.cfg_dwell = 8'd9; cfg_if.cfg_last = 1'b0;
    tick(); check("cfg_blocked", 3'd4, 1, 1, 3'd1, 0, 0);
    cfg_if.cfg_valid = 1'b0;

    add_idle(0,1,0,1);             // stop beats hold
    add(1,0,0,0, 3'd1, 3'd0, 0);   // replay: entry 1 must still be (4,d0)
    add(0,0,0,0, 3'd1, 3'd0, 0);
    add(0,0,0,0, 3'd1, 3'd0, 0);
    add(0,0,0,0, 3'd4, 3'd1, 0);
    add(0,0,0,0, 3'd7, 3'd2, 0);
    add_idle(0,0,0,1);
    add_idle(1,0,0,1);             // start+stop in IDLE: stay idle
    run("table_kept");

    // Full-depth loop: no last bits, all dwell 0.
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 3'(7 - i), 8'd0, 1'b0);
    add(1,0,0,0, 3'd7, 3'd0, 0);
    for (int i = 1; i < 8; i++) add(0,0,0,0, 3'(7 - i), 3'(i), 0);
    add(0,0,0,0, 3'd7, 3'd0, 1);
    add(0,0,0,0, 3'd6, 3'd1, 0);
    add_idle(0,1,0,1);
    run("depth8");

    // Reset mid-sequence clears the table too.
    add(1,0,0,0, 3'd7, 3'd0, 0);
    add(0,0,0,0, 3'd6, 3'd1, 0);
    add(0,0,0,0, 3'd5, 3'd2, 0);
    run("pre_rst");
    rst = 1'b1; start = 1'b1;
    tick(); check("mid_rst", 3'd0, 0, 0, 3'd0, 0, 1);
    rst = 1'b0; start = 1'b0;
    tick(); check("mid_rst_idle", 3'd0, 0, 0, 3'd0, 0, 1);
    add(1,0,0,0, 3'd0, 3'd0, 0);
    add(0,0,0,0, 3'd0, 3'd1, 0);
    add_idle(0,0,0,1);
    run("cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
